// File: rtl/arp_pkg.sv
// Shared FSM encoding, ARP opcodes and address constants for the ARP controller.
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_REQ,
    WAIT_REQ_DONE,
    WAIT_REPLY,
    TX_RPL,
    WAIT_RPL_DONE
  } arp_state_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_peer_t;

  localparam logic        ARP_OP_REQ = 1'b0;
  localparam logic        ARP_OP_RPL = 1'b1;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/arp_ctrl_if.sv
// ARP controller bus: receive-side results, transmit commands and resolve requests.
interface arp_ctrl_if;
  import arp_pkg::*;

  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        tx_done;
  logic        req_start;
  logic [31:0] req_ip;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        busy;
  logic        resolved;
  logic [47:0] resolved_mac;
  logic        timeout_err;

  modport master (
    output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done, req_start, req_ip,
    input  arp_tx_en, arp_tx_type, des_mac, des_ip, busy, resolved, resolved_mac, timeout_err
  );

  modport slave (
    input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done, req_start, req_ip,
    output arp_tx_en, arp_tx_type, des_mac, des_ip, busy, resolved, resolved_mac, timeout_err
  );

endinterface

// File: rtl/arp_cache.sv
// Single-entry IP->MAC cache; lookup is combinational, updates land on the next edge.
module arp_cache
  import arp_pkg::*;
(
  input  logic        gmii_clk,
  input  logic        sys_rst_n,
  input  logic        wr_vld,
  input  arp_peer_t   wr_peer,
  input  logic        rx_vld,
  input  arp_peer_t   rx_peer,
  input  logic [31:0] lookup_ip,
  output logic        hit,
  output logic [47:0] hit_mac
);

  logic      valid;
  arp_peer_t entry;

  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (wr_vld) begin
      valid <= 1'b1;
      entry <= wr_peer;
    end else if (rx_vld && valid && (rx_peer.ip == entry.ip)) begin
      entry.mac <= rx_peer.mac;
    end
  end

  assign hit     = valid && (lookup_ip == entry.ip);
  assign hit_mac = entry.mac;

endmodule

// File: rtl/arp_ctrl.sv
// ARP resolve/reply controller with retry timer; define ARP_CACHE_EN for a one-entry
// result cache that answers repeat lookups without transmitting.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 125000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       gmii_clk,
  input  logic       sys_rst_n,
  arp_ctrl_if.slave  arp
);

  localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int            RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY);

  arp_state_t    state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic [31:0]   req_ip_q;
  logic          pending_rpl;
  arp_peer_t     requester;
  logic          start_held;
  logic [31:0]   start_ip;
  logic          ret_flag;

  logic          rx_req;
  logic          rx_rpl_match;
  logic          idle_start;
  logic [31:0]   idle_ip;
  logic          cache_hit;
  logic [47:0]   cache_mac;

  assign rx_req       = arp.arp_rx_done && (arp.arp_rx_type == ARP_OP_REQ);
  assign rx_rpl_match = arp.arp_rx_done && (arp.arp_rx_type == ARP_OP_RPL) &&
                        (arp.src_ip == req_ip_q);
  // A start parked behind a reply is served before any fresh req_start.
  assign idle_start   = start_held || arp.req_start;
  assign idle_ip      = start_held ? start_ip : arp.req_ip;
  assign arp.busy     = (state != IDLE);

`ifdef ARP_CACHE_EN
  arp_cache u_cache (
    .gmii_clk  (gmii_clk),
    .sys_rst_n (sys_rst_n),
    .wr_vld    ((state == WAIT_REPLY) && rx_rpl_match),
    .wr_peer   ('{mac: arp.src_mac, ip: req_ip_q}),
    .rx_vld    (arp.arp_rx_done),
    .rx_peer   ('{mac: arp.src_mac, ip: arp.src_ip}),
    .lookup_ip (idle_ip),
    .hit       (cache_hit),
    .hit_mac   (cache_mac)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_mac = '0;
`endif

  // Transmit outputs are loaded on entry to TX_REQ/TX_RPL so the pulse coincides with that state.
  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      arp.arp_tx_en    <= 1'b0;
      arp.arp_tx_type  <= 1'b0;
      arp.des_mac      <= '0;
      arp.des_ip       <= '0;
      arp.resolved     <= 1'b0;
      arp.resolved_mac <= '0;
      arp.timeout_err  <= 1'b0;
      timer            <= '0;
      retry_cnt        <= '0;
      req_ip_q         <= '0;
      pending_rpl      <= 1'b0;
      requester        <= '0;
      start_held       <= 1'b0;
      start_ip         <= '0;
      ret_flag         <= 1'b0;
    end else begin
      arp.arp_tx_en   <= 1'b0;
      arp.resolved    <= 1'b0;
      arp.timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pending_rpl) begin
            state           <= TX_RPL;
            arp.arp_tx_en   <= 1'b1;
            arp.arp_tx_type <= ARP_OP_RPL;
            arp.des_mac     <= requester.mac;
            arp.des_ip      <= requester.ip;
            pending_rpl     <= 1'b0;
            if (arp.req_start && !start_held) begin
              start_held <= 1'b1;
              start_ip   <= arp.req_ip;
            end
          end else if (idle_start) begin
            start_held <= 1'b0;
            if (cache_hit) begin
              arp.resolved     <= 1'b1;
              arp.resolved_mac <= cache_mac;
            end else begin
              state           <= TX_REQ;
              arp.arp_tx_en   <= 1'b1;
              arp.arp_tx_type <= ARP_OP_REQ;
              arp.des_mac     <= BCAST_MAC;
              arp.des_ip      <= idle_ip;
              req_ip_q        <= idle_ip;
              retry_cnt       <= '0;
            end
          end
        end
        TX_REQ: state <= WAIT_REQ_DONE;
        WAIT_REQ_DONE: begin
          if (arp.tx_done) begin
            timer <= '0;
            state <= WAIT_REPLY;
          end
        end
        WAIT_REPLY: begin
          if (rx_rpl_match) begin
            arp.resolved     <= 1'b1;
            arp.resolved_mac <= arp.src_mac;
            state            <= IDLE;
          end else if (pending_rpl) begin
            ret_flag        <= 1'b1;
            state           <= TX_RPL;
            arp.arp_tx_en   <= 1'b1;
            arp.arp_tx_type <= ARP_OP_RPL;
            arp.des_mac     <= requester.mac;
            arp.des_ip      <= requester.ip;
            pending_rpl     <= 1'b0;
          end else if (timer == T_LAST) begin
            if (retry_cnt == R_LAST) begin
              arp.timeout_err <= 1'b1;
              state           <= IDLE;
            end else begin
              retry_cnt       <= retry_cnt + RW'(1);
              state           <= TX_REQ;
              arp.arp_tx_en   <= 1'b1;
              arp.arp_tx_type <= ARP_OP_REQ;
              arp.des_mac     <= BCAST_MAC;
              arp.des_ip      <= req_ip_q;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TX_RPL: state <= WAIT_RPL_DONE;
        WAIT_RPL_DONE: begin
          if (arp.tx_done) begin
            ret_flag <= 1'b0;
            state    <= ret_flag ? WAIT_REPLY : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Requests are captured in every state; the newest requester wins.
      if (rx_req) begin
        pending_rpl <= 1'b1;
        requester   <= '{mac: arp.src_mac, ip: arp.src_ip};
      end
    end
  end

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed-random bench for arp_ctrl: resolve, retry/timeout, reply service, collisions, reset.
module tb_arp_ctrl;
  import arp_pkg::*;

  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 3;

  logic gmii_clk = 1'b0;
  logic sys_rst_n;

  arp_ctrl_if sif ();

  arp_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .gmii_clk  (gmii_clk),
    .sys_rst_n (sys_rst_n),
    .arp       (sif.slave)
  );

  always #4 gmii_clk = ~gmii_clk;

  int cyc = 0, n_tx = 0, n_res = 0, n_to = 0;
  int errors = 0, checks = 0;

  always @(posedge gmii_clk) begin
    cyc <= cyc + 1;
    if (sif.arp_tx_en)   n_tx  <= n_tx + 1;
    if (sif.resolved)    n_res <= n_res + 1;
    if (sif.timeout_err) n_to  <= n_to + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return sif.arp_tx_en;
      1:       return sif.resolved;
      default: return sif.timeout_err;
    endcase
  endfunction

  task automatic wait_out(input int sel, input string tag, input int budget, output int t);
    int k = 0;
    while (pick(sel) !== 1'b1 && k < budget) begin
      @(negedge gmii_clk);
      k++;
    end
    t = cyc;
    check(tag, {63'd0, pick(sel)}, 64'd1);
  endtask

  task automatic do_start(input logic [31:0] ip);
    @(negedge gmii_clk);
    sif.req_start = 1'b1;
    sif.req_ip    = ip;
    @(negedge gmii_clk);
    sif.req_start = 1'b0;
  endtask

  task automatic do_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    @(negedge gmii_clk);
    sif.arp_rx_done = 1'b1;
    sif.arp_rx_type = typ;
    sif.src_mac     = mac;
    sif.src_ip      = ip;
    @(negedge gmii_clk);
    sif.arp_rx_done = 1'b0;
  endtask

  task automatic do_tx_done(output int t);
    @(negedge gmii_clk);
    sif.tx_done = 1'b1;
    @(negedge gmii_clk);
    sif.tx_done = 1'b0;
    t = cyc;
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_en"}, {63'd0, sif.arp_tx_en}, 64'd0);
    check({tag, "_tx_type"}, {63'd0, sif.arp_tx_type}, 64'd0);
    check({tag, "_busy"}, {63'd0, sif.busy}, 64'd0);
    check({tag, "_resolved"}, {63'd0, sif.resolved}, 64'd0);
    check({tag, "_timeout"}, {63'd0, sif.timeout_err}, 64'd0);
    check({tag, "_des_mac"}, {16'd0, sif.des_mac}, 64'd0);
    check({tag, "_des_ip"}, {32'd0, sif.des_ip}, 64'd0);
    check({tag, "_res_mac"}, {16'd0, sif.resolved_mac}, 64'd0);
  endtask

  initial begin
    #(8 * 40000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] mac_a, mac_q, mac_x;
    logic [31:0] ip_a, ip_q;
    int t0, t1, t2, t3, d, base_tx, base_res, base_to;

    sif.arp_rx_done = 1'b0; sif.arp_rx_type = 1'b0; sif.src_mac = '0; sif.src_ip = '0;
    sif.tx_done = 1'b0; sif.req_start = 1'b0; sif.req_ip = '0;
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (3) @(negedge gmii_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge gmii_clk);

    // Basic resolve of 192.168.1.10; early reply and busy req_start must be ignored.
    ip_a  = 32'hC0A8_010A;
    mac_a = 48'h0011_2233_4455;
    do_start(ip_a);
    wait_out(0, "req1_seen", 10, t0);
    check("req1_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_REQ});
    check("req1_des_mac", {16'd0, sif.des_mac}, {16'd0, BCAST_MAC});
    check("req1_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_a});
    check("req1_busy", {63'd0, sif.busy}, 64'd1);
    base_res = n_res;
    do_rx(ARP_OP_RPL, mac_a, ip_a);
    do_start(32'hC0A8_0163);
    check("req1_des_ip_stable", {32'd0, sif.des_ip}, {32'd0, ip_a});
    do_tx_done(t1);
    base_tx = n_tx;
    repeat (3) @(negedge gmii_clk);
    check("early_rpl_discarded", 64'(n_res - base_res), 64'd0);
    do_rx(ARP_OP_RPL, rand_mac(), 32'hC0A8_01FE);
    check("foreign_rpl_ignored", {63'd0, sif.resolved}, 64'd0);
    do_rx(ARP_OP_RPL, mac_a, ip_a);
    check("req1_resolved", {63'd0, sif.resolved}, 64'd1);
    check("req1_res_mac", {16'd0, sif.resolved_mac}, {16'd0, mac_a});
    @(negedge gmii_clk);
    check("req1_res_pulse_end", {63'd0, sif.resolved}, 64'd0);
    check("req1_idle", {63'd0, sif.busy}, 64'd0);
    repeat (20) @(negedge gmii_clk);
    check("busy_start_dropped", 64'(n_tx - base_tx), 64'd0);

`ifdef ARP_CACHE_EN
    base_tx = n_tx;
    do_start(ip_a);
    check("cache_resolved", {63'd0, sif.resolved}, 64'd1);
    check("cache_mac", {16'd0, sif.resolved_mac}, {16'd0, mac_a});
    repeat (5) @(negedge gmii_clk);
    check("cache_no_tx", 64'(n_tx - base_tx), 64'd0);
`endif

    // Request from 192.168.1.102 while idle is answered.
    ip_q  = 32'hC0A8_0166;
    mac_q = rand_mac();
    do_rx(ARP_OP_REQ, mac_q, ip_q);
    wait_out(0, "rpl_seen", 10, t0);
    check("rpl_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_RPL});
    check("rpl_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_q});
    check("rpl_des_mac", {16'd0, sif.des_mac}, {16'd0, mac_q});
    do_tx_done(t1);
    @(negedge gmii_clk);
    check("rpl_idle", {63'd0, sif.busy}, 64'd0);

    // No reply: MAX_RETRY+1 requests, each TIMEOUT_CYC after its tx_done, then one timeout.
    ip_a    = 32'hC0A8_0128;
    base_tx = n_tx;
    base_to = n_to;
    base_res = n_res;
    do_start(ip_a);
    t1 = 0;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      wait_out(0, "retry_seen", 2 * TIMEOUT_CYC, t0);
      check("retry_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_a});
      if (i > 0) check("retry_gap", 64'(t0 - t1), 64'(TIMEOUT_CYC));
      repeat ($urandom_range(0, 3)) @(negedge gmii_clk);
      do_tx_done(t1);
    end
    wait_out(2, "timeout_seen", 2 * TIMEOUT_CYC, t0);
    check("timeout_gap", 64'(t0 - t1), 64'(TIMEOUT_CYC));
    repeat (3) @(negedge gmii_clk);
    check("timeout_count", 64'(n_to - base_to), 64'd1);
    check("timeout_tx_count", 64'(n_tx - base_tx), 64'(MAX_RETRY + 1));
    check("timeout_no_resolve", 64'(n_res - base_res), 64'd0);
    check("timeout_idle", {63'd0, sif.busy}, 64'd0);

    // Request arriving in WAIT_REPLY: reply detour, timer resumes, later reply resolves.
    ip_a  = 32'hC0A8_0114;
    mac_a = rand_mac();
    ip_q  = 32'hC0A8_01C8;
    mac_q = rand_mac();
    do_start(ip_a);
    wait_out(0, "det_req_seen", 10, t0);
    do_tx_done(t0);
    d = $urandom_range(10, 40);
    repeat (d) @(negedge gmii_clk);
    do_rx(ARP_OP_REQ, mac_q, ip_q);
    wait_out(0, "det_rpl_seen", 10, t1);
    check("det_rpl_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_RPL});
    check("det_rpl_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_q});
    check("det_rpl_des_mac", {16'd0, sif.des_mac}, {16'd0, mac_q});
    repeat (2) @(negedge gmii_clk);
    do_tx_done(t2);
    wait_out(0, "det_retry_seen", 2 * TIMEOUT_CYC, t3);
    check("det_retry_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_REQ});
    check("det_retry_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_a});
    check("det_retry_des_mac", {16'd0, sif.des_mac}, {16'd0, BCAST_MAC});
    // The cycle that hands WAIT_REPLY over to the reply transmit does not advance the timer.
    check("det_timer_resume", 64'((t1 - t0) + (t3 - t2)), 64'(TIMEOUT_CYC + 1));
    do_tx_done(t0);
    repeat (5) @(negedge gmii_clk);
    do_rx(ARP_OP_RPL, mac_a, ip_a);
    check("det_resolved", {63'd0, sif.resolved}, 64'd1);
    check("det_res_mac", {16'd0, sif.resolved_mac}, {16'd0, mac_a});

    // Request received in the same cycle IDLE sees req_start: reply first, then the request.
    ip_a  = 32'hC0A8_0132;
    mac_a = rand_mac();
    ip_q  = 32'hC0A8_01C9;
    mac_q = rand_mac();
    @(negedge gmii_clk);
    sif.arp_rx_done = 1'b1; sif.arp_rx_type = ARP_OP_REQ; sif.src_mac = mac_q; sif.src_ip = ip_q;
    @(negedge gmii_clk);
    sif.arp_rx_done = 1'b0;
    sif.req_start = 1'b1; sif.req_ip = ip_a;
    @(negedge gmii_clk);
    sif.req_start = 1'b0;
    wait_out(0, "col_rpl_seen", 10, t0);
    check("col_rpl_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_RPL});
    check("col_rpl_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_q});
    do_tx_done(t1);
    wait_out(0, "col_req_seen", 10, t0);
    check("col_req_type", {63'd0, sif.arp_tx_type}, {63'd0, ARP_OP_REQ});
    check("col_req_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_a});
    do_tx_done(t1);
    mac_x = rand_mac();
    do_rx(ARP_OP_RPL, mac_x, ip_a);
    check("col_resolved", {63'd0, sif.resolved}, 64'd1);
    check("col_res_mac", {16'd0, sif.resolved_mac}, {16'd0, mac_x});

    // Reset in WAIT_REQ_DONE aborts silently; the next request works normally.
    ip_a = 32'hC0A8_011E;
    do_start(ip_a);
    wait_out(0, "rst_req_seen", 10, t0);
    repeat (2) @(negedge gmii_clk);
    base_res = n_res;
    base_to  = n_to;
    sys_rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    repeat (3) @(negedge gmii_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge gmii_clk);
    check("midrst_no_resolve", 64'(n_res - base_res), 64'd0);
    check("midrst_no_timeout", 64'(n_to - base_to), 64'd0);
    mac_a = rand_mac();
    do_start(ip_a);
    wait_out(0, "post_rst_req_seen", 10, t0);
    check("post_rst_des_ip", {32'd0, sif.des_ip}, {32'd0, ip_a});
    do_tx_done(t1);
    do_rx(ARP_OP_RPL, mac_a, ip_a);
    check("post_rst_resolved", {63'd0, sif.resolved}, 64'd1);
    check("post_rst_res_mac", {16'd0, sif.resolved_mac}, {16'd0, mac_a});

    repeat (3) @(negedge gmii_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arp_ctrl.md
ARP_CTRL -- requirements
Module: arp_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 125000, gmii_clk cycles to wait for an ARP reply (1 ms at 125 MHz).
REQ-002 Parameter MAX_RETRY, default 3, number of request retransmissions after the first attempt.
REQ-003 gmii_clk  input  1  clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 arp_rx_done  input  1  one-cycle pulse: ARP packet received and fields valid.
REQ-006 arp_rx_type  input  1  received type: 0 = request, 1 = reply.
REQ-007 src_mac / src_ip  input  48 / 32  sender MAC and IP of the received packet, valid with arp_rx_done.
REQ-008 tx_done  input  1  one-cycle pulse: ARP transmitter finished the frame.
REQ-009 req_start  input  1  one-cycle pulse: resolve req_ip.
REQ-010 req_ip  input  32  IP to resolve, sampled with req_start.
REQ-011 arp_tx_en  output  1  one-cycle pulse: start ARP transmit.
REQ-012 arp_tx_type  output  1  0 = request, 1 = reply; valid with arp_tx_en.
REQ-013 des_mac / des_ip  output  48 / 32  target MAC and IP; stable from arp_tx_en until tx_done.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 resolved  output  1  one-cycle pulse: req_ip resolved; resolved_mac output (48) valid and held until the next resolution.
REQ-016 timeout_err  output  1  one-cycle pulse: retries exhausted without a reply.

Function
REQ-017 FSM states: IDLE, TX_REQ, WAIT_REQ_DONE, WAIT_REPLY, TX_RPL, WAIT_RPL_DONE.
REQ-018 Received request (arp_rx_done && !arp_rx_type) in any state sets pending_rpl and latches src_mac/src_ip; a later request before service overwrites the latched pair.
REQ-019 IDLE: pending_rpl -> TX_RPL; else req_start -> latch req_ip, clear retry_cnt, -> TX_REQ; if both occur in the same cycle, the reply wins and req_start is latched for service on return to IDLE.
REQ-020 req_start while busy and no start already latched SHALL be ignored.
REQ-021 TX_REQ: arp_tx_en=1 for one cycle, arp_tx_type=0, des_mac=48'hFF_FF_FF_FF_FF_FF, des_ip=latched req_ip -> WAIT_REQ_DONE.
REQ-022 WAIT_REQ_DONE: on tx_done clear timer -> WAIT_REPLY.
REQ-023 WAIT_REPLY: reply (arp_rx_done && arp_rx_type && src_ip==latched req_ip) -> resolved pulse next cycle, resolved_mac=src_mac, -> IDLE; a reply from any other IP is ignored.
REQ-024 WAIT_REPLY: timer increments each cycle; at TIMEOUT_CYC-1 with retry_cnt<MAX_RETRY -> retry_cnt+1, -> TX_REQ; with retry_cnt==MAX_RETRY -> timeout_err pulse, -> IDLE.
REQ-025 WAIT_REPLY with pending_rpl -> TX_RPL with a return flag set; the timer freezes and resumes from its held value on return.
REQ-026 TX_RPL: arp_tx_en=1 for one cycle, arp_tx_type=1, des_mac/des_ip = latched requester; clear pending_rpl -> WAIT_RPL_DONE.
REQ-027 WAIT_RPL_DONE: on tx_done -> WAIT_REPLY if return flag set (flag cleared), else IDLE.
REQ-028 A matching reply arriving in a non-WAIT_REPLY state SHALL be discarded.
REQ-029 Timer width SHALL be $clog2(TIMEOUT_CYC); retry_cnt SHALL have no wrap-around.

Reset
REQ-030 On sys_rst_n low, immediately: state=IDLE; arp_tx_en, arp_tx_type, busy, resolved, timeout_err, pending_rpl, return flag, latched start = 0; des_mac, des_ip, resolved_mac, timer, retry_cnt = 0.
REQ-031 Reset mid-transaction SHALL abort without a resolved or timeout_err pulse.

Configuration
REQ-032 Macro ARP_CACHE_EN defined: one-entry cache {valid, ip, mac} is written on every resolution; req_start in IDLE with req_ip==cached ip and valid -> resolved pulse 1 cycle later with the cached MAC, no transmit; a received reply or request from cached ip refreshes the cached MAC.
REQ-033 Macro undefined: no cache; every req_start transmits.

Structure
REQ-034 Shared package arp_pkg: FSM state enum, ARP_OP_REQ/ARP_OP_RPL constants, BCAST_MAC constant.
REQ-035 Sub-module arp_cache (single entry, used only under ARP_CACHE_EN); timer and FSM stay in arp_ctrl.

Verification
REQ-036 req_start, req_ip=192.168.1.10 -> arp_tx_en with type 0, des_mac=FF..FF; after tx_done, reply from src_ip 192.168.1.10, src_mac 00-11-22-33-44-55 -> resolved, resolved_mac=0x001122334455.
REQ-037 No reply, TIMEOUT_CYC=100, MAX_RETRY=3 -> 4 request pulses spaced by 100 cycles after each tx_done, then a single timeout_err pulse.
REQ-038 Request from 192.168.1.102 while in IDLE -> arp_tx_en with type 1, des_ip=192.168.1.102, des_mac=latched src_mac.
REQ-039 Request received during WAIT_REPLY -> reply sent, timer resumes from its held value, and a later matching reply still resolves.
REQ-040 ARP_CACHE_EN: second req_start for the same IP -> resolved 1 cycle later, no arp_tx_en.
REQ-041 sys_rst_n low during WAIT_REQ_DONE -> all outputs 0, no resolved/timeout_err; a new req_start after reset works normally.
